// File: rtl/branch_target_predictor.sv
// Tagged direct-mapped branch target buffer with saturating direction counters.
// FETCH gets a zero-latency next-PC prediction; DECODE allocates entries; EXECUTE trains them.
module branch_target_predictor #(
    parameter int ADDR_W   = 32,
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int CTR_INIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] f_pc,
    output logic              f_predict_valid,
    output logic [ADDR_W-1:0] f_predict_addr,
    input  logic              d_is_branch,
    input  logic [ADDR_W-1:0] d_pc,
    input  logic [ADDR_W-1:0] d_target_addr,
    input  logic              x_valid,
    input  logic [ADDR_W-1:0] x_pc,
    input  logic              x_taken,
    input  logic              flush
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(CTR_INIT);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);
    localparam logic [ADDR_W-1:0]   PC_STEP = ADDR_W'(4);

    logic                valid_q  [ENTRIES];
    logic                valid_d  [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [TAG_W-1:0]    tag_d    [ENTRIES];
    logic [ADDR_W-1:0]   target_q [ENTRIES];
    logic [ADDR_W-1:0]   target_d [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    logic [CTR_BITS-1:0] ctr_d    [ENTRIES];

    logic [IDX_W-1:0] f_idx, d_idx, x_idx;
    logic [TAG_W-1:0] f_tag, d_tag, x_tag;
    logic             f_hit, d_hit, x_hit;
    logic             f_taken;
    logic             train_drop;

    assign f_idx = f_pc[IDX_W+1:2];
    assign d_idx = d_pc[IDX_W+1:2];
    assign x_idx = x_pc[IDX_W+1:2];
    assign f_tag = f_pc[ADDR_W-1:IDX_W+2];
    assign d_tag = d_pc[ADDR_W-1:IDX_W+2];
    assign x_tag = x_pc[ADDR_W-1:IDX_W+2];

    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign d_hit = valid_q[d_idx] && (tag_q[d_idx] == d_tag);
    assign x_hit = valid_q[x_idx] && (tag_q[x_idx] == x_tag);

    // A replacing allocate at the trained index discards that cycle's training.
    assign train_drop = d_is_branch && !d_hit && (d_idx == x_idx);

    // Zero-latency lookup against pre-edge table state.
    always_comb begin
        f_taken         = f_hit && ctr_q[f_idx][CTR_BITS-1];
        f_predict_valid = f_taken;
        f_predict_addr  = f_taken ? target_q[f_idx] : f_pc + PC_STEP;
    end

    // Next table state: flush, else training then allocate/refresh.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
            end
        end else begin
            if (x_valid && x_hit && !train_drop) begin
                if (x_taken && ctr_q[x_idx] != CTR_MAX) begin
                    ctr_d[x_idx] = ctr_q[x_idx] + CTR_ONE;
                end else if (!x_taken && ctr_q[x_idx] != '0) begin
                    ctr_d[x_idx] = ctr_q[x_idx] - CTR_ONE;
                end
            end
            if (d_is_branch) begin
                target_d[d_idx] = d_target_addr;
                if (!d_hit) begin
                    valid_d[d_idx] = 1'b1;
                    tag_d[d_idx]   = d_tag;
                    ctr_d[d_idx]   = CTR_RST;
                end
            end
        end
    end

    // Table registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RST;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Parametrised, tagged, direct-mapped branch target buffer with N-bit saturating direction counters. It is the successor to the fixed single-table branch predictor. It sits between FETCH, DECODE and EXECUTE:
- FETCH gets a zero-latency next-PC prediction.
- DECODE allocates entries for discovered branches.
- EXECUTE trains the counters with explicitly tagged resolution feedback, carrying its own PC instead of relying on implicit pipeline alignment.

## Interface
- ADDR_W, 32: PC/target width.
- ENTRIES, 16: table depth; power of two, ≥2. IDX_W = log2(ENTRIES).
- CTR_BITS, 2: direction counter width, 1..4.
- CTR_INIT, 1: counter value on allocate/reset; must be < 2^CTR_BITS (default = weakly not-taken).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- f_pc  in  ADDR_W  FETCH-stage PC.
- f_predict_valid  out  1  predicted taken (hit and counter MSB set).
- f_predict_addr  out  ADDR_W  predicted next PC.
- d_is_branch  in  1  DECODE found a branch this cycle.
- d_pc  in  ADDR_W  PC of the DECODE instruction.
- d_target_addr  in  ADDR_W  decoded branch target.
- x_valid  in  1  EXECUTE resolution feedback present.
- x_pc  in  ADDR_W  PC of the resolved branch.
- x_taken  in  1  resolved direction.
- flush  in  1  synchronous invalidate of the whole table.

## Operation
- **Address split:**
  - pc[1:0] are ignored.
  - index = pc[IDX_W+1:2].
  - tag = pc[ADDR_W-1:IDX_W+2].
- **Entry contents:** valid, tag, target[ADDR_W], ctr[CTR_BITS].
- **Lookup (combinational from f_pc and registered table state):**
  - hit = valid & tag match.
  - taken = hit & ctr[CTR_BITS-1].
  - f_predict_valid = taken.
  - f_predict_addr = taken ? target : f_pc+4, modulo 2^ADDR_W (0xFFFFFFFC → 0x0).
- **Allocate, on a clock edge with d_is_branch=1, at index(d_pc):**
  - Valid entry with matching tag: refresh the target only; ctr is unchanged.
  - Otherwise: overwrite the entry with valid=1, new tag, d_target_addr, ctr=CTR_INIT. Aliased entries are silently evicted.
- **Train, on a clock edge with x_valid=1, at index(x_pc):**
  - Applies only if the entry is valid and the tag matches. A miss is a no-op; no allocation.
  - x_taken=1: ctr increments, saturating at 2^CTR_BITS-1.
  - x_taken=0: ctr decrements, saturating at 0.
- **Simultaneous events in one cycle:**
  - Allocate and train at different indices: both apply.
  - Same index, allocate replaces the entry: allocate wins and the training is dropped.
  - Same index, allocate is a refresh (tag hit): the target refresh and the counter training both apply.
  - flush=1: clears every valid bit; d_is_branch and x_valid are ignored that cycle. Targets and counters are left unchanged (don't-care).
- **Reset:**
  - All valid bits = 0, ctr = CTR_INIT, target = 0.
  - Outputs are then f_predict_valid=0 and f_predict_addr=f_pc+4.
  - Asserting rst_n low mid-operation clears the table immediately, without waiting for a clock edge.

## Timing
- Prediction has zero-cycle latency: a combinational path from f_pc to both outputs.
- Table writes take effect at the rising edge. A lookup in the same cycle sees pre-edge state (no write-to-read bypass).
- An allocate at edge N is visible to a lookup of the same PC in cycle N+1. The same applies to training.
- There is no backpressure; every input is sampled on every edge.

## Test plan
- **Reset:** rst_n=0, then release; f_pc=0x1008 → f_predict_valid=0, f_predict_addr=0x100C. Also f_pc=0xFFFFFFFC → addr 0x0.
- **Allocate then train:**
  - d_is_branch=1, d_pc=0x100C, d_target_addr=0x1014; next cycle f_pc=0x100C → valid=0, addr=0x1010 (ctr=1).
  - Then x_valid=1, x_pc=0x100C, x_taken=1; next cycle → valid=1, addr=0x1014.
- **Saturation:** from ctr=1, apply taken ×4 → ctr=3 and prediction taken. Not-taken ×1 → still taken. Not-taken ×1 → not taken. Not-taken ×3 → ctr=0, and the next single taken still predicts not-taken.
- **Aliasing:**
  - Allocate 0x1014→0x1000 and train it taken.
  - Allocate 0x1054→0x2000 (same index 5, different tag).
  - f_pc=0x1014 → valid=0, addr=0x1018. f_pc=0x1054 → ctr=CTR_INIT, not taken.
  - x_valid with x_pc=0x1014 → no change to the entry.
- **Same-cycle collisions:**
  - Allocate 0x1054 together with training x_pc=0x1014 taken → entry holds tag(0x1054) with ctr=1.
  - Refresh 0x1054 with target 0x3000 together with training 0x1054 taken → target=0x3000, ctr=2.
- **Flush and asynchronous reset:**
  - flush=1 together with d_is_branch for 0x1008 → all lookups miss the next cycle and 0x1008 is not allocated.
  - Assert rst_n low between clock edges while an entry is taken-predicting → f_predict_valid drops to 0 immediately.
